// File: rtl/llki_pkg.sv
// Shared LLKI constants and the key-loader FSM state type for the multi-channel mock TSS lock.
package llki_pkg;

   localparam int MOCK_TSS_MC_NUM_KEY_WORDS = 2;

   localparam logic [64*MOCK_TSS_MC_NUM_KEY_WORDS-1:0] MOCK_TSS_MC_EXP_KEY =
      128'h0123_4567_89AB_CDEF_A5A5_A5A5_0000_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_LOADED = 2'd2,
      ST_CLEAR  = 2'd3
   } mock_tss_state_t;

endpackage

// File: rtl/mock_tss_key_loader.sv
// LLKI discrete key loader: word-serial load into a KEY_WORDS x 64b register and word-serial clear.
module mock_tss_key_loader
   import llki_pkg::*;
#(
   parameter int KEY_WORDS = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [63:0]               key_data,
   input  logic                      key_valid,
   input  logic                      clear_key,
   output logic                      key_ready,
   output logic                      key_complete,
   output logic                      clear_ack,
   output logic [64*KEY_WORDS-1:0]   key,
   output mock_tss_state_t           state
);

   // idx must reach KEY_WORDS so the clear can spend one extra cycle raising the ack
   localparam int IDX_W = $clog2(KEY_WORDS + 1);

   mock_tss_state_t          state_q, state_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [64*KEY_WORDS-1:0]  key_q, key_d;
   logic                     ready_q, ready_d;
   logic                     complete_q, complete_d;
   logic                     ack_q, ack_d;
   logic                     accept;

   assign accept = key_valid & ready_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      key_d   = key_q;
      ack_d   = 1'b0;
      if (clear_key && (state_q != ST_CLEAR)) begin
         // clear beats a coincident key word, which is simply dropped
         state_d = ST_CLEAR;
         idx_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  key_d[63:0] = key_data;
                  if (KEY_WORDS == 1) begin
                     state_d = ST_LOADED;
                     idx_d   = '0;
                  end else begin
                     state_d = ST_LOAD;
                     idx_d   = IDX_W'(1);
                  end
               end
            end
            ST_LOAD: begin
               if (accept) begin
                  key_d[idx_q*64 +: 64] = key_data;
                  if (idx_q == IDX_W'(KEY_WORDS - 1)) begin
                     state_d = ST_LOADED;
                     idx_d   = '0;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end
            end
            ST_LOADED: begin
               state_d = ST_LOADED;
            end
            default: begin
               if (idx_q == IDX_W'(KEY_WORDS)) begin
                  ack_d   = 1'b1;
                  idx_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  key_d[idx_q*64 +: 64] = 64'h0;
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         endcase
      end
      ready_d    = (state_d == ST_IDLE) || (state_d == ST_LOAD);
      complete_d = (state_d == ST_LOADED);
   end

   // ready is registered so it stays low throughout reset and rises on the first edge after
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         key_q      <= '0;
         ready_q    <= 1'b0;
         complete_q <= 1'b0;
         ack_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         key_q      <= key_d;
         ready_q    <= ready_d;
         complete_q <= complete_d;
         ack_q      <= ack_d;
      end
   end

   assign key_ready    = ready_q;
   assign key_complete = complete_q;
   assign clear_ack    = ack_q;
   assign key          = key_q;
   assign state        = state_q;

endmodule

// File: rtl/mock_tss_lock_mc.sv
// Multi-channel mock TSS lock: per-channel XOR with (EXP_KEY ^ loaded key), optional output gating until loaded.
module mock_tss_lock_mc
   import llki_pkg::*;
#(
   parameter int                        KEY_WORDS = 4,
   parameter int                        NUM_CH    = 4,
   parameter int                        CH_W      = 32,
   parameter bit                        LOCK_MODE = 1'b1,
   parameter logic [64*KEY_WORDS-1:0]   EXP_KEY   = '0
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst_n,
   input  logic [63:0]               llkid_key_data,
   input  logic                      llkid_key_valid,
   output logic                      llkid_key_ready,
   output logic                      llkid_key_complete,
   input  logic                      llkid_clear_key,
   output logic                      llkid_clear_key_ack,
   input  logic [NUM_CH*CH_W-1:0]    core_data,
   input  logic [NUM_CH-1:0]         core_valid,
   output logic [NUM_CH*CH_W-1:0]    out_data,
   output logic [NUM_CH-1:0]         out_valid,
   output logic                      key_match
);

   localparam int DW = NUM_CH * CH_W;

   logic [64*KEY_WORDS-1:0]  key;
   mock_tss_state_t          state;
   logic [DW-1:0]            mask;
   logic                     gate;
   logic [DW-1:0]            out_data_q, out_data_d;
   logic [NUM_CH-1:0]        out_valid_q, out_valid_d;
   logic                     key_match_q, key_match_d;

   mock_tss_key_loader #(
      .KEY_WORDS (KEY_WORDS)
   ) u_loader (
      .clk          (sys_clk),
      .rst_n        (sys_rst_n),
      .key_data     (llkid_key_data),
      .key_valid    (llkid_key_valid),
      .clear_key    (llkid_clear_key),
      .key_ready    (llkid_key_ready),
      .key_complete (llkid_key_complete),
      .clear_ack    (llkid_clear_key_ack),
      .key          (key),
      .state        (state)
   );

   // key bits above DW never reach a channel
   assign mask = EXP_KEY[DW-1:0] ^ key[DW-1:0];
   assign gate = LOCK_MODE && (state != ST_LOADED);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign out_data_d[c*CH_W +: CH_W] =
         gate ? '0 : (core_data[c*CH_W +: CH_W] ^ mask[c*CH_W +: CH_W]);
   end

   always_comb begin
      out_valid_d = core_valid;
      key_match_d = (state == ST_LOADED) && (key == EXP_KEY);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         out_data_q  <= '0;
         out_valid_q <= '0;
         key_match_q <= 1'b0;
      end else begin
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         key_match_q <= key_match_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign key_match = key_match_q;

endmodule

// File: tb/tb_mock_tss_lock_mc.sv
// Directed bench for mock_tss_lock_mc: 2 key words, 2 x 32b channels, lock mode on.
module tb_mock_tss_lock_mc;
   import llki_pkg::*;

   localparam int KW = MOCK_TSS_MC_NUM_KEY_WORDS;
   localparam logic [63:0] W0   = 64'hA5A5_A5A5_0000_FFFF;
   localparam logic [63:0] W1   = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] CORE = 64'h1111_2222_3333_4444;
   localparam logic [63:0] BAD  = 64'hB4B4_8787_3333_BBBB;

   logic          sys_clk = 1'b0;
   logic          sys_rst_n;
   logic [63:0]   llkid_key_data;
   logic          llkid_key_valid;
   logic          llkid_key_ready;
   logic          llkid_key_complete;
   logic          llkid_clear_key;
   logic          llkid_clear_key_ack;
   logic [63:0]   core_data;
   logic [1:0]    core_valid;
   logic [63:0]   out_data;
   logic [1:0]    out_valid;
   logic          key_match;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   mock_tss_lock_mc #(
      .KEY_WORDS (KW),
      .NUM_CH    (2),
      .CH_W      (32),
      .LOCK_MODE (1'b1),
      .EXP_KEY   (MOCK_TSS_MC_EXP_KEY)
   ) dut (
      .sys_clk             (sys_clk),
      .sys_rst_n           (sys_rst_n),
      .llkid_key_data      (llkid_key_data),
      .llkid_key_valid     (llkid_key_valid),
      .llkid_key_ready     (llkid_key_ready),
      .llkid_key_complete  (llkid_key_complete),
      .llkid_clear_key     (llkid_clear_key),
      .llkid_clear_key_ack (llkid_clear_key_ack),
      .core_data           (core_data),
      .core_valid          (core_valid),
      .out_data            (out_data),
      .out_valid           (out_valid),
      .key_match           (key_match)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic clear_and_wait(input string tag);
      logic seen;
      seen = 1'b0;
      llkid_clear_key = 1'b1;
      tick();
      llkid_clear_key = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (llkid_clear_key_ack === 1'b1) begin seen = 1'b1; break; end
      end
      chk_cnt++;
      if (seen !== 1'b1) $display("FAIL %s_ack_timeout: ack seen=%b required=1", tag, seen);
      else pass_cnt++;
   endtask

   task automatic load2(input logic [63:0] a, input logic [63:0] b);
      llkid_key_valid = 1'b1;
      llkid_key_data  = a;
      tick();
      llkid_key_data  = b;
      tick();
      llkid_key_valid = 1'b0;
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      llkid_key_data = '0; llkid_key_valid = 1'b0; llkid_clear_key = 1'b0;
      core_data = '0; core_valid = '0;
      #12;
      chk_cnt++; if (llkid_key_ready !== 1'b0) $display("FAIL rst_ready: got %b required 0", llkid_key_ready); else pass_cnt++;
      chk_cnt++; if (llkid_key_complete !== 1'b0) $display("FAIL rst_complete: got %b required 0", llkid_key_complete); else pass_cnt++;
      chk_cnt++; if (llkid_clear_key_ack !== 1'b0) $display("FAIL rst_ack: got %b required 0", llkid_clear_key_ack); else pass_cnt++;
      chk_cnt++; if (out_valid !== 2'b00) $display("FAIL rst_out_valid: got %b required 00", out_valid); else pass_cnt++;
      chk_cnt++; if (key_match !== 1'b0) $display("FAIL rst_key_match: got %b required 0", key_match); else pass_cnt++;
      core_data = CORE; core_valid = 2'b11;
      #2 sys_rst_n = 1'b1;
      tick();
      chk_cnt++; if (out_data !== 64'h0) $display("FAIL locked_out_data: got %h required 0", out_data); else pass_cnt++;
      chk_cnt++; if (out_valid !== 2'b11) $display("FAIL locked_out_valid: got %b required 11", out_valid); else pass_cnt++;
      chk_cnt++; if (llkid_key_ready !== 1'b1) $display("FAIL idle_ready: got %b required 1", llkid_key_ready); else pass_cnt++;
      chk_cnt++; if (llkid_key_complete !== 1'b0) $display("FAIL idle_complete: got %b required 0", llkid_key_complete); else pass_cnt++;
      core_valid = 2'b01;
      tick();
      chk_cnt++; if (out_valid !== 2'b01) $display("FAIL valid_follow: got %b required 01", out_valid); else pass_cnt++;
      core_valid = 2'b11;
      tick();
   endtask

   task automatic test_load_good();
      llkid_key_valid = 1'b1;
      llkid_key_data  = W0;
      tick();
      chk_cnt++; if (llkid_key_complete !== 1'b0) $display("FAIL mid_load_complete: got %b required 0", llkid_key_complete); else pass_cnt++;
      chk_cnt++; if (llkid_key_ready !== 1'b1) $display("FAIL mid_load_ready: got %b required 1", llkid_key_ready); else pass_cnt++;
      llkid_key_data = W1;
      tick();
      chk_cnt++; if (llkid_key_complete !== 1'b1) $display("FAIL load_complete: got %b required 1", llkid_key_complete); else pass_cnt++;
      chk_cnt++; if (llkid_key_ready !== 1'b0) $display("FAIL loaded_ready: got %b required 0", llkid_key_ready); else pass_cnt++;
      chk_cnt++; if (key_match !== 1'b0) $display("FAIL key_match_early: got %b required 0", key_match); else pass_cnt++;
      // extra word while loaded must be dropped
      llkid_key_data = 64'hDEAD_BEEF_DEAD_BEEF;
      tick();
      llkid_key_valid = 1'b0;
      chk_cnt++; if (key_match !== 1'b1) $display("FAIL key_match_good: got %b required 1", key_match); else pass_cnt++;
      chk_cnt++; if (out_data !== CORE) $display("FAIL good_out_data: got %h required %h", out_data, CORE); else pass_cnt++;
      tick();
      chk_cnt++; if (out_data !== CORE) $display("FAIL extra_word_dropped: got %h required %h", out_data, CORE); else pass_cnt++;
      chk_cnt++; if (llkid_key_complete !== 1'b1) $display("FAIL extra_word_complete: got %b required 1", llkid_key_complete); else pass_cnt++;
   endtask

   task automatic test_clear();
      // clear held for two cycles: the second request lands in ST_CLEAR and is ignored
      llkid_clear_key = 1'b1;
      tick();
      chk_cnt++; if (llkid_key_complete !== 1'b0) $display("FAIL clr_complete: got %b required 0", llkid_key_complete); else pass_cnt++;
      chk_cnt++; if (llkid_key_ready !== 1'b0) $display("FAIL clr_ready: got %b required 0", llkid_key_ready); else pass_cnt++;
      chk_cnt++; if (llkid_clear_key_ack !== 1'b0) $display("FAIL clr_ack_c0: got %b required 0", llkid_clear_key_ack); else pass_cnt++;
      tick();
      llkid_clear_key = 1'b0;
      chk_cnt++; if (key_match !== 1'b0) $display("FAIL clr_key_match: got %b required 0", key_match); else pass_cnt++;
      chk_cnt++; if (llkid_clear_key_ack !== 1'b0) $display("FAIL clr_ack_c1: got %b required 0", llkid_clear_key_ack); else pass_cnt++;
      tick();
      chk_cnt++; if (llkid_clear_key_ack !== 1'b0) $display("FAIL clr_ack_c2: got %b required 0", llkid_clear_key_ack); else pass_cnt++;
      tick();
      chk_cnt++; if (llkid_clear_key_ack !== 1'b1) $display("FAIL clr_ack_c3: got %b required 1", llkid_clear_key_ack); else pass_cnt++;
      chk_cnt++; if (dut.u_loader.key !== 128'h0) $display("FAIL clr_key_zero: got %h required 0", dut.u_loader.key); else pass_cnt++;
      chk_cnt++; if (out_data !== 64'h0) $display("FAIL clr_out_data: got %h required 0", out_data); else pass_cnt++;
      chk_cnt++; if (llkid_key_ready !== 1'b1) $display("FAIL clr_idle_ready: got %b required 1", llkid_key_ready); else pass_cnt++;
      tick();
      chk_cnt++; if (llkid_clear_key_ack !== 1'b0) $display("FAIL clr_ack_pulse: got %b required 0", llkid_clear_key_ack); else pass_cnt++;
   endtask

   task automatic test_wrong_key();
      load2(64'h0, W1);
      chk_cnt++; if (llkid_key_complete !== 1'b1) $display("FAIL bad_complete: got %b required 1", llkid_key_complete); else pass_cnt++;
      tick();
      chk_cnt++; if (out_data !== BAD) $display("FAIL bad_out_data: got %h required %h", out_data, BAD); else pass_cnt++;
      chk_cnt++; if (key_match !== 1'b0) $display("FAIL bad_key_match: got %b required 0", key_match); else pass_cnt++;
      clear_and_wait("bad");
   endtask

   task automatic test_clear_collide();
      llkid_clear_key = 1'b1;
      llkid_key_valid = 1'b1;
      llkid_key_data  = W0;
      tick();
      llkid_clear_key = 1'b0;
      llkid_key_valid = 1'b0;
      chk_cnt++; if (llkid_key_ready !== 1'b0) $display("FAIL col_clear_wins: ready got %b required 0", llkid_key_ready); else pass_cnt++;
      for (int i = 0; i < 10; i++) begin
         if (llkid_clear_key_ack === 1'b1) break;
         tick();
      end
      chk_cnt++; if (llkid_clear_key_ack !== 1'b1) $display("FAIL col_ack_timeout: got %b required 1", llkid_clear_key_ack); else pass_cnt++;
      chk_cnt++; if (dut.u_loader.key[63:0] !== 64'h0) $display("FAIL col_word_dropped: got %h required 0", dut.u_loader.key[63:0]); else pass_cnt++;
      llkid_key_valid = 1'b1;
      llkid_key_data  = W0;
      tick();
      llkid_key_valid = 1'b0;
      chk_cnt++; if (llkid_key_complete !== 1'b0) $display("FAIL col_one_word: complete got %b required 0", llkid_key_complete); else pass_cnt++;
      llkid_key_valid = 1'b1;
      llkid_key_data  = W1;
      tick();
      llkid_key_valid = 1'b0;
      chk_cnt++; if (llkid_key_complete !== 1'b1) $display("FAIL col_reload: complete got %b required 1", llkid_key_complete); else pass_cnt++;
      tick();
      chk_cnt++; if (key_match !== 1'b1) $display("FAIL col_key_match: got %b required 1", key_match); else pass_cnt++;
      clear_and_wait("col");
   endtask

   task automatic test_reset_midload();
      llkid_key_valid = 1'b1;
      llkid_key_data  = W0;
      tick();
      llkid_key_valid = 1'b0;
      #2 sys_rst_n = 1'b0;
      #1;
      chk_cnt++; if (out_valid !== 2'b00) $display("FAIL mrst_out_valid: got %b required 00", out_valid); else pass_cnt++;
      chk_cnt++; if (llkid_key_ready !== 1'b0) $display("FAIL mrst_ready: got %b required 0", llkid_key_ready); else pass_cnt++;
      chk_cnt++; if (dut.u_loader.key !== 128'h0) $display("FAIL mrst_key: got %h required 0", dut.u_loader.key); else pass_cnt++;
      chk_cnt++; if (out_data !== 64'h0) $display("FAIL mrst_out_data: got %h required 0", out_data); else pass_cnt++;
      #3 sys_rst_n = 1'b1;
      tick();
      chk_cnt++; if (llkid_key_ready !== 1'b1) $display("FAIL mrst_idle_ready: got %b required 1", llkid_key_ready); else pass_cnt++;
      chk_cnt++; if (llkid_key_complete !== 1'b0) $display("FAIL mrst_complete: got %b required 0", llkid_key_complete); else pass_cnt++;
      load2(W0, W1);
      chk_cnt++; if (llkid_key_complete !== 1'b1) $display("FAIL mrst_reload: complete got %b required 1", llkid_key_complete); else pass_cnt++;
      tick();
      chk_cnt++; if (out_data !== CORE) $display("FAIL mrst_out_data_good: got %h required %h", out_data, CORE); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_load_good();
      test_clear();
      test_wrong_key();
      test_clear_collide();
      test_reset_midload();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: sim time exceeded, checks so far %0d/%0d", pass_cnt, chk_cnt);
      $fatal(1);
   end

endmodule
